conv3x3_window: RTL and testbench
=================================

CONV3X3_WINDOW -- requirements
Module: conv3x3_window

Interface
REQ-001 Parameter HRES, default 1280, active pixels per line.
REQ-002 Parameter VRES, default 720, active lines per frame.
REQ-003 clk_in  input  1  system clock; all logic in this single clock domain.
REQ-004 rst_in  input  1  system reset, synchronous, active-high.
REQ-005 data_in  input  [2:0][7:0]  one kernel column of unsigned pixels; [0] top row, [1] centre row, [2] bottom row.
REQ-006 hcount_in  input  11  column index of data_in.
REQ-007 vcount_in  input  10  centre-row index of data_in.
REQ-008 data_valid_in  input  1  data_in, hcount_in and vcount_in are valid this cycle (a "beat").
REQ-009 kernel_select_in  input  2  kernel choice: 0 identity, 1 gaussian, 2 sharpen, 3 laplacian.
REQ-010 pixel_data_out  output  8  filtered centre pixel.
REQ-011 hcount_out  output  11  column of pixel_data_out.
REQ-012 vcount_out  output  10  row of pixel_data_out.
REQ-013 data_valid_out  output  1  outputs are valid this cycle.

Function
REQ-014 On each beat, the 3x3 window SHALL shift: col2 <= col1, col1 <= col0, col0 <= data_in; with no beat, the window and its metadata SHALL hold.
REQ-015 The hcount/vcount of each beat SHALL travel with its column, so the centre metadata is always that of col1.
REQ-016 The window SHALL be valid only after at least two beats have been accepted since reset.
REQ-017 The pipeline SHALL have four stages: window capture; nine products; sum; shift plus clamp into output registers.
REQ-018 For the column of beat k, outputs SHALL assert exactly 4 cycles after beat k+1 is presented, one output per qualifying beat, and the pipeline SHALL advance every cycle.
REQ-019 Pixels SHALL be zero-extended to 9-bit signed; coefficients SHALL be 8-bit signed; products 17-bit signed; sum 21-bit signed.
REQ-020 Kernels (row-major, shift): identity [0 0 0;0 1 0;0 0 0] >>0; gaussian [1 2 1;2 4 2;1 2 1] >>4; sharpen [0 -1 0;-1 5 -1;0 -1 0] >>0; laplacian [0 -1 0;-1 4 -1;0 -1 0] >>0.
REQ-021 The shift SHALL be arithmetic; the result SHALL clamp negative values to 0 and values above 255 to 255.
REQ-022 If the centre hcount is 0 or HRES-1, or the centre vcount is 0 or VRES-1, pixel_data_out SHALL equal the unfiltered centre pixel (col1[1]).
REQ-023 kernel_select_in SHALL be latched only on a beat with hcount_in==0 and vcount_in==0; the active kernel SHALL stay constant for the rest of the frame.
REQ-024 Border detection and kernel choice SHALL be carried down the pipeline with their data, so a frame-boundary kernel change never mixes kernels within one output.

Reset
REQ-025 While rst_in is high: data_valid_out=0, pixel_data_out=0, hcount_out=0, vcount_out=0, all pipeline valid bits=0, window-fill count=0, latched kernel=identity.
REQ-026 A reset mid-frame SHALL drop all in-flight results, and no data_valid_out SHALL assert until two new beats have been accepted.

Structure
REQ-027 Package conv_pkg SHALL hold the kernel_sel_t enum, the coefficient table as a typedef'd 3x3 array of signed 8-bit values, the shift table, and the width localparams (PIX_W=8, COEF_W=8, SUM_W=21).
REQ-028 One sub-module, conv_clamp (21-bit signed shift and saturate to 8-bit unsigned), SHALL be factored out; everything else stays flat.

Verification
REQ-029 Bench parameters: HRES=8, VRES=6.
REQ-030 Flat field of 100, gaussian -> every interior output = 100; borders = 100; latency exactly 4 cycles measured from beat k+1.
REQ-031 Flat field of 100, laplacian -> interior = 0; sharpen -> interior = 100.
REQ-032 Single 255 impulse at (3,3) on a zero field, sharpen -> (3,3) = 255 (clamped); (2,3), (4,3), (3,2), (3,4) = 0 (negatives clamped); gaussian -> (3,3) = 63.
REQ-033 kernel_select_in changed from 0 to 2 mid-frame -> the rest of that frame stays identity; the next frame uses sharpen from its first output.
REQ-034 data_valid_in gapped randomly (50% duty) -> the output sequence and values match the gap-free run exactly; no output appears during a stall without a matching beat.
REQ-035 rst_in pulsed during line 3 -> data_valid_out=0 the following cycle; the first post-reset output follows the second post-reset beat by 4 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_pkg: widths, kernel enum, coefficient and shift tables          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package conv_pkg;

  localparam int PIX_W   = 8;
  localparam int COEF_W  = 8;
  localparam int PROD_W  = 17;
  localparam int SUM_W   = 21;
  localparam int SHIFT_W = 3;

  typedef enum logic [1:0] {
    KSEL_IDENTITY  = 2'd0,
    KSEL_GAUSSIAN  = 2'd1,
    KSEL_SHARPEN   = 2'd2,
    KSEL_LAPLACIAN = 2'd3
  } kernel_sel_t;

  typedef logic signed [COEF_W-1:0]  coef_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [SUM_W-1:0]   sum_t;
  typedef logic        [SHIFT_W-1:0] shift_t;
  typedef coef_t kernel_coef_t [0:2][0:2];

  // Indexed [kernel][row][col]; row 0 is the top row, col 0 the oldest column.
  localparam kernel_coef_t COEF_TABLE [0:3] = '{
    '{'{ 8'sd0,  8'sd0,  8'sd0}, '{ 8'sd0,  8'sd1,  8'sd0}, '{ 8'sd0,  8'sd0,  8'sd0}},
    '{'{ 8'sd1,  8'sd2,  8'sd1}, '{ 8'sd2,  8'sd4,  8'sd2}, '{ 8'sd1,  8'sd2,  8'sd1}},
    '{'{ 8'sd0, -8'sd1,  8'sd0}, '{-8'sd1,  8'sd5, -8'sd1}, '{ 8'sd0, -8'sd1,  8'sd0}},
    '{'{ 8'sd0, -8'sd1,  8'sd0}, '{-8'sd1,  8'sd4, -8'sd1}, '{ 8'sd0, -8'sd1,  8'sd0}}
  };

  localparam shift_t SHIFT_TABLE [0:3] = '{3'd0, 3'd4, 3'd0, 3'd0};

  // Unsigned pixel times signed coefficient; explicit extension keeps widths exact.
  function automatic prod_t pix_mul(input logic [PIX_W-1:0] pix, input coef_t coef);
    prod_t pix_ext;
    prod_t coef_ext;
    pix_ext  = {{(PROD_W-PIX_W){1'b0}}, pix};
    coef_ext = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
    return pix_ext * coef_ext;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_window_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv3x3_window_if: column stream in, filtered pixel stream out       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface conv3x3_window_if;

  logic [2:0][7:0] data_in;
  logic [10:0]     hcount_in;
  logic [9:0]      vcount_in;
  logic            data_valid_in;
  logic [1:0]      kernel_select_in;
  logic [7:0]      pixel_data_out;
  logic [10:0]     hcount_out;
  logic [9:0]      vcount_out;
  logic            data_valid_out;

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in, kernel_select_in,
    input  pixel_data_out, hcount_out, vcount_out, data_valid_out
  );

  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in, kernel_select_in,
    output pixel_data_out, hcount_out, vcount_out, data_valid_out
  );

endinterface
`default_nettype wire

// File: rtl/conv_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_clamp: arithmetic right shift, saturate to 8-bit unsigned       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module conv_clamp
  import conv_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_in,
  input  logic [SHIFT_W-1:0]      shift_in,
  output logic [PIX_W-1:0]        pix_out
);

  sum_t shifted;

  always_comb begin
    shifted = sum_in >>> shift_in;
    pix_out = shifted[PIX_W-1:0];
    if (shifted[SUM_W-1]) begin
      pix_out = '0;
    end else if (|shifted[SUM_W-2:PIX_W]) begin
      pix_out = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv3x3_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv3x3_window: 3x3 convolution over a column stream, 4-stage pipe   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module conv3x3_window
  import conv_pkg::*;
#(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  logic            clk_in,
  input  logic            rst_in,
  conv3x3_window_if.slave bus
);

  localparam logic [10:0] H_LAST = 11'(HRES - 1);
  localparam logic [9:0]  V_LAST = 10'(VRES - 1);

  typedef logic [2:0][PIX_W-1:0] column_t;

  // Stage 1: window and per-column metadata
  column_t     col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic [10:0] hc0_q, hc0_d, hc1_q, hc1_d;
  logic [9:0]  vc0_q, vc0_d, vc1_q, vc1_d;
  kernel_sel_t ks0_q, ks0_d, ks1_q, ks1_d;
  kernel_sel_t kernel_q, kernel_d;
  logic [1:0]  fill_q, fill_d;
  logic        win_valid_q, win_valid_d;

  // Stage 2: products
  prod_t            prod_q [9];
  prod_t            prod_d [9];
  logic [PIX_W-1:0] s2_centre_q, s2_centre_d;
  logic             s2_border_q, s2_border_d;
  kernel_sel_t      s2_kernel_q, s2_kernel_d;
  logic [10:0]      s2_hc_q, s2_hc_d;
  logic [9:0]       s2_vc_q, s2_vc_d;
  logic             s2_valid_q, s2_valid_d;

  // Stage 3: sum
  sum_t             sum_q, sum_d;
  logic [PIX_W-1:0] s3_centre_q, s3_centre_d;
  logic             s3_border_q, s3_border_d;
  kernel_sel_t      s3_kernel_q, s3_kernel_d;
  logic [10:0]      s3_hc_q, s3_hc_d;
  logic [9:0]       s3_vc_q, s3_vc_d;
  logic             s3_valid_q, s3_valid_d;

  // Stage 4: output registers
  logic [PIX_W-1:0] pix_out_q, pix_out_d, clamped;
  logic [10:0]      hc_out_q, hc_out_d;
  logic [9:0]       vc_out_q, vc_out_d;
  logic             valid_out_q, valid_out_d;

  logic        frame_start;
  kernel_sel_t beat_kernel;

  // The kernel rides with each column so a frame-boundary change never mixes kernels.
  assign frame_start = (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign beat_kernel = frame_start ? kernel_sel_t'(bus.kernel_select_in) : kernel_q;

  always_comb begin
    col0_d      = col0_q;
    col1_d      = col1_q;
    col2_d      = col2_q;
    hc0_d       = hc0_q;
    hc1_d       = hc1_q;
    vc0_d       = vc0_q;
    vc1_d       = vc1_q;
    ks0_d       = ks0_q;
    ks1_d       = ks1_q;
    kernel_d    = kernel_q;
    fill_d      = fill_q;
    win_valid_d = bus.data_valid_in && (fill_q != 2'd0);
    if (bus.data_valid_in) begin
      col0_d   = bus.data_in;
      col1_d   = col0_q;
      col2_d   = col1_q;
      hc0_d    = bus.hcount_in;
      hc1_d    = hc0_q;
      vc0_d    = bus.vcount_in;
      vc1_d    = vc0_q;
      ks0_d    = beat_kernel;
      ks1_d    = ks0_q;
      kernel_d = beat_kernel;
      if (fill_q != 2'd2) begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      prod_d[r*3+0] = pix_mul(col2_q[r], COEF_TABLE[ks1_q][r][0]);
      prod_d[r*3+1] = pix_mul(col1_q[r], COEF_TABLE[ks1_q][r][1]);
      prod_d[r*3+2] = pix_mul(col0_q[r], COEF_TABLE[ks1_q][r][2]);
    end
    s2_centre_d = col1_q[1];
    s2_border_d = (hc1_q == '0) || (hc1_q == H_LAST) || (vc1_q == '0) || (vc1_q == V_LAST);
    s2_kernel_d = ks1_q;
    s2_hc_d     = hc1_q;
    s2_vc_d     = vc1_q;
    s2_valid_d  = win_valid_q;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
    s3_centre_d = s2_centre_q;
    s3_border_d = s2_border_q;
    s3_kernel_d = s2_kernel_q;
    s3_hc_d     = s2_hc_q;
    s3_vc_d     = s2_vc_q;
    s3_valid_d  = s2_valid_q;
  end

  conv_clamp u_clamp (
    .sum_in   (sum_q),
    .shift_in (SHIFT_TABLE[s3_kernel_q]),
    .pix_out  (clamped)
  );

  always_comb begin
    pix_out_d   = pix_out_q;
    hc_out_d    = hc_out_q;
    vc_out_d    = vc_out_q;
    valid_out_d = s3_valid_q;
    if (s3_valid_q) begin
      pix_out_d = s3_border_q ? s3_centre_q : clamped;
      hc_out_d  = s3_hc_q;
      vc_out_d  = s3_vc_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col0_q      <= '0;
      col1_q      <= '0;
      col2_q      <= '0;
      hc0_q       <= '0;
      hc1_q       <= '0;
      vc0_q       <= '0;
      vc1_q       <= '0;
      ks0_q       <= KSEL_IDENTITY;
      ks1_q       <= KSEL_IDENTITY;
      kernel_q    <= KSEL_IDENTITY;
      fill_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      col2_q      <= col2_d;
      hc0_q       <= hc0_d;
      hc1_q       <= hc1_d;
      vc0_q       <= vc0_d;
      vc1_q       <= vc1_d;
      ks0_q       <= ks0_d;
      ks1_q       <= ks1_d;
      kernel_q    <= kernel_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= '0;
      end
      s2_centre_q <= '0;
      s2_border_q <= 1'b0;
      s2_kernel_q <= KSEL_IDENTITY;
      s2_hc_q     <= '0;
      s2_vc_q     <= '0;
      s2_valid_q  <= 1'b0;
      sum_q       <= '0;
      s3_centre_q <= '0;
      s3_border_q <= 1'b0;
      s3_kernel_q <= KSEL_IDENTITY;
      s3_hc_q     <= '0;
      s3_vc_q     <= '0;
      s3_valid_q  <= 1'b0;
      pix_out_q   <= '0;
      hc_out_q    <= '0;
      vc_out_q    <= '0;
      valid_out_q <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= prod_d[i];
      end
      s2_centre_q <= s2_centre_d;
      s2_border_q <= s2_border_d;
      s2_kernel_q <= s2_kernel_d;
      s2_hc_q     <= s2_hc_d;
      s2_vc_q     <= s2_vc_d;
      s2_valid_q  <= s2_valid_d;
      sum_q       <= sum_d;
      s3_centre_q <= s3_centre_d;
      s3_border_q <= s3_border_d;
      s3_kernel_q <= s3_kernel_d;
      s3_hc_q     <= s3_hc_d;
      s3_vc_q     <= s3_vc_d;
      s3_valid_q  <= s3_valid_d;
      pix_out_q   <= pix_out_d;
      hc_out_q    <= hc_out_d;
      vc_out_q    <= vc_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.pixel_data_out = pix_out_q;
  assign bus.hcount_out     = hc_out_q;
  assign bus.vcount_out     = vc_out_q;
  assign bus.data_valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv3x3_window: scoreboard bench for conv3x3_window (8x6 frames)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_conv3x3_window;

  localparam int HRES = 8;
  localparam int VRES = 6;
  localparam int ALL  = HRES * VRES;

  localparam int KC [0:3][0:8] = '{
    '{0,  0, 0,  0, 1,  0, 0,  0, 0},
    '{1,  2, 1,  2, 4,  2, 1,  2, 1},
    '{0, -1, 0, -1, 5, -1, 0, -1, 0},
    '{0, -1, 0, -1, 4, -1, 0, -1, 0}
  };
  localparam int KSH [0:3] = '{0, 4, 0, 0};

  typedef struct {
    int h;
    int v;
    int pix;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_k = 0;
  int   beats = 0;
  exp_t pend;
  exp_t mon_e;
  exp_t sbq [$];
  int   img   [0:VRES-1][0:HRES-1];
  int   got   [0:VRES-1][0:HRES-1];
  int   saved [0:VRES-1][0:HRES-1];

  conv3x3_window_if bus ();

  conv3x3_window #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_pix(int h, int v, int k);
    int s;
    s = 0;
    if (h == 0 || h == HRES-1 || v == 0 || v == VRES-1) return img[v][h];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += KC[k][(dr+1)*3 + (dc+1)] * img[v+dr][h+dc];
    s = s >>> KSH[k];
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
    return s;
  endfunction

  task automatic fill_image(input int pattern, input int val);
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        case (pattern)
          0:       img[v][h] = val;
          1:       img[v][h] = (h == 3 && v == 3) ? val : 0;
          default: img[v][h] = (h*h*29 + v*v*13 + h*v*7 + val) % 256;
        endcase
  endtask

  task automatic clear_got();
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        got[v][h] = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.data_valid_in = 1'b0;
    end
  endtask

  task automatic beat(input int h, input int v, input int ksel);
    @(posedge clk); #1;
    bus.data_valid_in    = 1'b1;
    bus.hcount_in        = 11'(h);
    bus.vcount_in        = 10'(v);
    bus.kernel_select_in = 2'(ksel);
    bus.data_in[0]       = 8'((v > 0) ? img[v-1][h] : 0);
    bus.data_in[1]       = 8'(img[v][h]);
    bus.data_in[2]       = 8'((v < VRES-1) ? img[v+1][h] : 0);
    if (h == 0 && v == 0) model_k = ksel;
    // The previous column completes when this beat lands; it appears 4 cycles on.
    if (beats > 0) begin
      pend.cyc = cyc + 4;
      sbq.push_back(pend);
    end
    pend.h   = h;
    pend.v   = v;
    pend.pix = ref_pix(h, v, model_k);
    beats++;
  endtask

  task automatic drive_frame(input int ksel0, input int ksel_late, input int late_v,
                             input bit gapped, input int max_beats);
    int n;
    n = 0;
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++) begin
        if (n == max_beats) return;
        if (gapped && $urandom_range(0, 1) == 1) idle(1);
        beat(h, v, (v >= late_v) ? ksel_late : ksel0);
        n++;
      end
  endtask

  task automatic do_reset();
    int c;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_valid_in = 1'b0;
    c = cyc;
    while (sbq.size() != 0 && sbq[$].cyc > c) void'(sbq.pop_back());
    beats   = 0;
    model_k = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_valid", bus.data_valid_out, 0);
    chk("midreset_pixel", bus.pixel_data_out, 0);
    chk("midreset_hcount", bus.hcount_out, 0);
    chk("midreset_vcount", bus.vcount_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.data_valid_out === 1'b1) begin
      if (bus.hcount_out < HRES && bus.vcount_out < VRES)
        got[bus.vcount_out][bus.hcount_out] = int'(bus.pixel_data_out);
      n_checks++;
      assert (sbq.size() != 0) else begin
        n_errors++;
        $error("FAIL spurious_output: observed valid at h=%0d v=%0d, expected none",
               bus.hcount_out, bus.vcount_out);
      end
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("out_pixel", bus.pixel_data_out, mon_e.pix);
        chk("out_hcount", bus.hcount_out, mon_e.h);
        chk("out_vcount", bus.vcount_out, mon_e.v);
        chk("out_cycle", cyc, mon_e.cyc);
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      chk("missing_output_valid", bus.data_valid_out, 1);
    end
  end

  initial begin
    bus.data_in          = '0;
    bus.hcount_in        = '0;
    bus.vcount_in        = '0;
    bus.data_valid_in    = 1'b0;
    bus.kernel_select_in = '0;
    clear_got();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", bus.data_valid_out, 0);
    chk("reset_pixel", bus.pixel_data_out, 0);
    chk("reset_hcount", bus.hcount_out, 0);
    chk("reset_vcount", bus.vcount_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Flat field through gaussian, laplacian, sharpen
    fill_image(0, 100); clear_got();
    drive_frame(1, 1, VRES, 1'b0, ALL); idle(6);
    chk("flat_gauss_interior", got[3][3], 100);
    chk("flat_gauss_border", got[0][0], 100);
    chk("flat_gauss_edge", got[2][7], 100);

    clear_got();
    drive_frame(3, 3, VRES, 1'b0, ALL); idle(6);
    chk("flat_lap_interior", got[2][2], 0);
    chk("flat_lap_border", got[0][3], 100);

    clear_got();
    drive_frame(2, 2, VRES, 1'b0, ALL); idle(6);
    chk("flat_sharp_interior", got[2][4], 100);

    // Impulse at (3,3)
    fill_image(1, 255); clear_got();
    drive_frame(2, 2, VRES, 1'b0, ALL); idle(6);
    chk("imp_sharp_centre", got[3][3], 255);
    chk("imp_sharp_left", got[3][2], 0);
    chk("imp_sharp_right", got[3][4], 0);
    chk("imp_sharp_up", got[2][3], 0);
    chk("imp_sharp_down", got[4][3], 0);

    clear_got();
    drive_frame(1, 1, VRES, 1'b0, ALL); idle(6);
    chk("imp_gauss_centre", got[3][3], 63);

    // Kernel request changes mid-frame; it takes effect at the next frame
    fill_image(2, 0); clear_got();
    drive_frame(0, 2, 2, 1'b0, ALL); idle(6);
    chk("midframe_identity", got[3][3], img[3][3]);
    clear_got();
    drive_frame(2, 2, VRES, 1'b0, ALL); idle(6);
    model_k = 2;
    chk("nextframe_sharpen", got[2][3], ref_pix(3, 2, 2));

    // Gap-free then gapped run of the same frame must agree
    fill_image(2, 17); clear_got();
    drive_frame(1, 1, VRES, 1'b0, ALL); idle(6);
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        saved[v][h] = got[v][h];
    clear_got();
    drive_frame(1, 1, VRES, 1'b1, ALL); idle(8);
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        if (!(v == VRES-1 && h == HRES-1))
          chk("gapped_vs_gapfree", got[v][h], saved[v][h]);

    // Reset during line 3, then a fresh frame
    fill_image(2, 99);
    drive_frame(3, 3, VRES, 1'b0, 3*HRES + 4);
    do_reset();
    fill_image(2, 5); clear_got();
    drive_frame(2, 2, VRES, 1'b0, ALL); idle(8);

    n_checks++;
    assert (sbq.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
